// File: rtl/mem_responder_4b.sv
// rtl/mem_responder_4b.sv - 4-byte memory responder with fixed latency pipeline and output buffer
// Request {type_[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}; response {type_[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}.
module mem_responder_4b #(
    parameter int p_mem_nwords = 256,
    parameter int p_latency    = 1,
    parameter int p_resp_depth = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [76:0] reqstream_msg,
    input  logic        reqstream_val,
    output logic        reqstream_rdy,
    output logic [46:0] respstream_msg,
    output logic        respstream_val,
    input  logic        respstream_rdy
);

    localparam int c_aw = $clog2(p_mem_nwords);
    localparam int c_cw = $clog2(p_resp_depth + 1);
    localparam int c_pw = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;

    logic [2:0]       req_type;
    logic [7:0]       req_opaque;
    logic [31:0]      req_addr;
    logic [1:0]       req_len;
    logic [31:0]      req_data;

    logic [31:0]      mem [p_mem_nwords];
    logic [c_aw-1:0]  idx;
    logic [1:0]       off;
    logic [2:0]       nb;
    logic [3:0]       be_base;
    logic [3:0]       be;
    logic [31:0]      dmask;
    logic [31:0]      bmask;
    logic [31:0]      cur;
    logic [31:0]      rd_data;
    logic [31:0]      wr_word;
    logic [31:0]      resp_data;
    logic             bad;
    logic             do_write;
    logic [46:0]      resp_new;

    logic             req_fire;
    logic             resp_fire;
    logic             enq;
    logic             deq;
    logic             buf_empty;
    logic             pipe_out_val;

    logic [p_latency-1:0] pipe_val;
    logic [46:0]      pipe_msg [p_latency];
    logic [46:0]      buf_msg [p_resp_depth];
    logic [c_pw-1:0]  head;
    logic [c_pw-1:0]  tail;
    logic [c_cw-1:0]  buf_cnt;
    logic [c_cw-1:0]  cnt;

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(p_resp_depth - 1)) ? '0 : p + c_pw'(1);
    endfunction

    assign {req_type, req_opaque, req_addr, req_len, req_data} = reqstream_msg;

    // Upper address bits fall away in the cast, so addresses wrap modulo the array size.
    assign idx = c_aw'(req_addr >> 2);
    assign off = req_addr[1:0];
    assign cur = mem[idx];

    always_comb begin
        nb      = 3'd4;
        be_base = 4'hF;
        dmask   = 32'hFFFF_FFFF;
        case (req_len)
            2'd1: begin nb = 3'd1; be_base = 4'h1; dmask = 32'h0000_00FF; end
            2'd2: begin nb = 3'd2; be_base = 4'h3; dmask = 32'h0000_FFFF; end
            2'd3: begin nb = 3'd3; be_base = 4'h7; dmask = 32'h00FF_FFFF; end
            default: ;
        endcase
        bad       = (({1'b0, off} + nb) > 3'd4) || (req_type > 3'd2);
        be        = be_base << off;
        bmask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        rd_data   = (cur >> {off, 3'b000}) & dmask;
        wr_word   = (cur & ~bmask) | ((req_data << {off, 3'b000}) & bmask);
        do_write  = req_fire && !bad && (req_type == 3'd1 || req_type == 3'd2);
        resp_data = (!bad && req_type == 3'd0) ? rd_data : 32'h0;
        resp_new  = {req_type, req_opaque, bad ? 2'b01 : 2'b00, req_len, resp_data};
    end

    // Credits cover pipeline plus buffer, so the pipeline never has to stall.
    assign reqstream_rdy  = reset && (cnt < c_cw'(p_resp_depth));
    assign req_fire       = reqstream_val && reqstream_rdy;

    assign buf_empty      = (buf_cnt == '0);
    assign pipe_out_val   = pipe_val[p_latency-1];
    assign respstream_val = !buf_empty || pipe_out_val;
    assign respstream_msg = buf_empty ? pipe_msg[p_latency-1] : buf_msg[head];
    assign resp_fire      = respstream_val && respstream_rdy;

    // The pipeline tail bypasses the buffer only when the buffer is empty and the sink takes it.
    assign enq = pipe_out_val && !(buf_empty && respstream_rdy);
    assign deq = !buf_empty && respstream_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_val <= '0;
            head     <= '0;
            tail     <= '0;
            buf_cnt  <= '0;
            cnt      <= '0;
        end else begin
            pipe_val[0] <= req_fire;
            for (int i = 1; i < p_latency; i++) begin
                pipe_val[i] <= pipe_val[i-1];
            end
            if (enq) tail <= ptr_inc(tail);
            if (deq) head <= ptr_inc(head);
            if (enq && !deq)      buf_cnt <= buf_cnt + c_cw'(1);
            else if (deq && !enq) buf_cnt <= buf_cnt - c_cw'(1);
            if (req_fire && !resp_fire)      cnt <= cnt + c_cw'(1);
            else if (resp_fire && !req_fire) cnt <= cnt - c_cw'(1);
        end
    end

    // Payload and storage carry no reset; validity lives in the control registers above.
    always_ff @(posedge clk) begin
        pipe_msg[0] <= resp_new;
        for (int i = 1; i < p_latency; i++) begin
            pipe_msg[i] <= pipe_msg[i-1];
        end
        if (enq) buf_msg[tail] <= pipe_msg[p_latency-1];
        if (do_write) mem[idx] <= wr_word;
    end

endmodule

// File: tb/tb_mem_responder_4b.sv
// tb/tb_mem_responder_4b.sv - randomized self-checking bench for mem_responder_4b against a byte-memory model
module tb_mem_responder_4b;

    localparam int NW    = 256;
    localparam int LAT   = 3;
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] reqstream_msg;
    logic        reqstream_val;
    logic        reqstream_rdy;
    logic [46:0] respstream_msg;
    logic        respstream_val;
    logic        respstream_rdy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  mem_b [NW*4];
    logic [46:0] exp_q [$];
    logic [46:0] got_q [$];

    always #5 clk = ~clk;

    mem_responder_4b #(
        .p_mem_nwords(NW),
        .p_latency(LAT),
        .p_resp_depth(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reqstream_msg(reqstream_msg),
        .reqstream_val(reqstream_val),
        .reqstream_rdy(reqstream_rdy),
        .respstream_msg(respstream_msg),
        .respstream_val(respstream_val),
        .respstream_rdy(respstream_rdy)
    );

    always @(negedge clk) begin
        if (reset && respstream_val && respstream_rdy) got_q.push_back(respstream_msg);
    end

    function automatic logic [46:0] model(input logic [2:0] t, input logic [7:0] op,
                                          input logic [31:0] a, input logic [1:0] ln,
                                          input logic [31:0] d);
        int w, o, nb;
        logic [31:0] r;
        w  = int'((a >> 2) % NW);
        o  = int'(a % 4);
        nb = (ln == 2'd0) ? 4 : int'(ln);
        r  = 32'h0;
        if (t > 3'd2 || o + nb > 4) return {t, op, 2'b01, ln, 32'h0};
        for (int i = 0; i < nb; i++) begin
            if (t == 3'd0) r[8*i +: 8] = mem_b[w*4 + o + i];
            else           mem_b[w*4 + o + i] = d[8*i +: 8];
        end
        return {t, op, 2'b00, ln, r};
    endfunction

    task automatic do_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                          input logic [1:0] ln, input logic [31:0] d);
        int n = 0;
        reqstream_msg = {t, op, a, ln, d};
        reqstream_val = 1'b1;
        @(negedge clk);
        while (!reqstream_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!reqstream_rdy) begin
            tests_run++;
            tests_failed++;
            $display("FAIL req_accept_timeout rdy=%b required=1", reqstream_rdy);
            @(posedge clk);
        end else begin
            @(posedge clk);
            exp_q.push_back(model(t, op, a, ln, d));
        end
        #1 reqstream_val = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        reqstream_val  = 1'b0;
        reqstream_msg  = '0;
        respstream_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (reqstream_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rdy got=%b required=0", reqstream_rdy);
        end
        tests_run++;
        if (respstream_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_val got=%b required=0", respstream_val);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (reqstream_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_rdy got=%b required=1", reqstream_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_init();
        logic [46:0] e, g;
        respstream_rdy = 1'b1;
        for (int w = 0; w < NW; w++) do_req(3'd2, 8'(w), 32'(w * 4), 2'd0, $urandom);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL init_resp got=%h required=%h", g, e);
            end
        end
    endtask

    task automatic test_directed();
        logic [46:0] ex [$];
        logic [46:0] g;
        respstream_rdy = 1'b1;
        do_req(3'd1, 8'h05, 32'h10,  2'd0, 32'hDEADBEEF);
        do_req(3'd0, 8'h06, 32'h10,  2'd0, 32'h0);
        do_req(3'd1, 8'h07, 32'h12,  2'd1, 32'h000000AA);
        do_req(3'd0, 8'h08, 32'h10,  2'd0, 32'h0);
        do_req(3'd0, 8'h09, 32'h11,  2'd2, 32'h0);
        do_req(3'd1, 8'h0A, 32'h00,  2'd0, 32'h11223344);
        do_req(3'd1, 8'h0B, 32'h03,  2'd2, 32'h0000FFFF);
        do_req(3'd0, 8'h0C, 32'h00,  2'd0, 32'h0);
        do_req(3'd1, 8'h0D, 32'h400, 2'd0, 32'hCAFEF00D);
        do_req(3'd0, 8'h0E, 32'h000, 2'd0, 32'h0);
        do_req(3'd5, 8'h0F, 32'h20,  2'd0, 32'h00001234);
        ex = '{{3'd1, 8'h05, 2'b00, 2'd0, 32'h0},
               {3'd0, 8'h06, 2'b00, 2'd0, 32'hDEADBEEF},
               {3'd1, 8'h07, 2'b00, 2'd1, 32'h0},
               {3'd0, 8'h08, 2'b00, 2'd0, 32'hDEAABEEF},
               {3'd0, 8'h09, 2'b00, 2'd2, 32'h0000AABE},
               {3'd1, 8'h0A, 2'b00, 2'd0, 32'h0},
               {3'd1, 8'h0B, 2'b01, 2'd2, 32'h0},
               {3'd0, 8'h0C, 2'b00, 2'd0, 32'h11223344},
               {3'd1, 8'h0D, 2'b00, 2'd0, 32'h0},
               {3'd0, 8'h0E, 2'b00, 2'd0, 32'hCAFEF00D},
               {3'd5, 8'h0F, 2'b01, 2'd0, 32'h0}};
        wait_drain();
        exp_q.delete();
        for (int i = 0; i < ex.size(); i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            tests_run++;
            if (g !== ex[i]) begin
                tests_failed++;
                $display("FAIL directed_%0d got=%h required=%h", i, g, ex[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [46:0] e, g;
        int n = 0;
        respstream_rdy = 1'b1;
        do_req(3'd0, 8'h20, $urandom, 2'd0, 32'h0);
        while (!respstream_val && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        tests_run++;
        if (n !== LAT - 1) begin
            tests_failed++;
            $display("FAIL latency edges_after_fire got=%0d required=%0d", n + 1, LAT);
        end
        for (int i = 0; i < 4; i++) do_req(3'd0, 8'(8'h30 + i), $urandom & 32'hFFFF_FFFC, 2'd0, 32'h0);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL latency_order got=%h required=%h", g, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [46:0] e, g, m0;
        logic [31:0] a;
        int accepted = 0;
        respstream_rdy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            a = $urandom & 32'hFFFF_FFFC;
            reqstream_msg = {3'd0, 8'(8'h40 + c), a, 2'd0, 32'h0};
            reqstream_val = 1'b1;
            @(negedge clk);
            if (reqstream_rdy) begin
                @(posedge clk);
                exp_q.push_back(model(3'd0, 8'(8'h40 + c), a, 2'd0, 32'h0));
                accepted++;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        reqstream_val = 1'b0;
        tests_run++;
        if (accepted !== DEPTH) begin
            tests_failed++;
            $display("FAIL bp_accepted got=%0d required=%0d", accepted, DEPTH);
        end
        tests_run++;
        if (reqstream_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_rdy_full got=%b required=0", reqstream_rdy);
        end
        m0 = respstream_msg;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (respstream_val !== 1'b1 || respstream_msg !== m0) begin
            tests_failed++;
            $display("FAIL bp_hold val=%b msg=%h required val=1 msg=%h", respstream_val, respstream_msg, m0);
        end
        respstream_rdy = 1'b1;
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL bp_drain got=%h required=%h", g, e);
            end
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (reqstream_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_rdy_after_drain got=%b required=1", reqstream_rdy);
        end
    endtask

    task automatic test_random();
        logic [46:0] e, g;
        bit done = 1'b0;
        fork
            begin
                logic [2:0]  t;
                logic [31:0] a;
                int r;
                for (int i = 0; i < 200; i++) begin
                    r = int'($urandom_range(0, 7));
                    t = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 6) ? 3'd2 : 3'($urandom_range(3, 7));
                    a = $urandom;
                    if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
                    do_req(t, 8'(i), a, 2'($urandom_range(0, 3)), $urandom);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 respstream_rdy = ($urandom_range(0, 2) != 0);
                end
            end
        join
        respstream_rdy = 1'b1;
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL random_resp got=%h required=%h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [46:0] e, g;
        respstream_rdy = 1'b0;
        do_req(3'd0, 8'h70, 32'h40, 2'd0, 32'h0);
        do_req(3'd0, 8'h71, 32'h44, 2'd0, 32'h0);
        repeat (LAT) @(posedge clk);
        #1;
        tests_run++;
        if (respstream_val !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_inflight val=%b required=1", respstream_val);
        end
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (respstream_val !== 1'b0 || reqstream_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async val=%b rdy=%b required 0 0", respstream_val, reqstream_rdy);
        end
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (reqstream_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_release_rdy got=%b required=1", reqstream_rdy);
        end
        @(posedge clk);
        #1 respstream_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (got_q.size() !== 0 || respstream_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_stale count=%0d val=%b required 0 0", got_q.size(), respstream_val);
        end
        do_req(3'd0, 8'h72, 32'h44, 2'd0, 32'h0);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL rst_mid_after got=%h required=%h", g, e);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_latency();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_responder_4b.md
Name: mem_responder_4b

Overview:
- Target-side endpoint for the 4-byte memory request/response streams that the processor and its imem/dmem queues issue.
- Accepts mem_req_4B_t requests on a val/rdy stream and performs read, write or init against an internal word-addressed register array.
- Returns one in-order mem_resp_4B_t per request after a fixed, parameterized latency.
- Used as a synthesizable backing memory for single-core processor integration and as a latency or backpressure source in tests.

Parameters:
- p_mem_nwords, 256: number of 32-bit words in storage. Power of two, at least 4.
- p_latency, 1: cycles from request acceptance to earliest response valid. Range 1..4.
- p_resp_depth, 2: maximum responses in flight (pipeline plus output buffer). Range 1..4, and at least p_latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- reqstream_msg  in  $bits(mem_req_4B_t)  request: type_, opaque, addr, len, data.
- reqstream_val  in  1  request valid.
- reqstream_rdy  out  1  request ready.
- respstream_msg  out  $bits(mem_resp_4B_t)  response: type_, opaque, test, len, data.
- respstream_val  out  1  response valid.
- respstream_rdy  in  1  response ready.

Behaviour:
- Handshakes:
  - A request fires when reqstream_val && reqstream_rdy on a rising edge.
  - A response fires when respstream_val && respstream_rdy.
  - Once respstream_val is high, it and respstream_msg hold stable until the response fires.
- Reset:
  - While reset==0: reqstream_rdy=0, respstream_val=0, in-flight count=0, all pipeline and buffer valid bits cleared.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all in-flight responses immediately, without waiting for an edge.
  - After reset deasserts, reqstream_rdy=1 in the first cycle.
- Credit counter (cnt, 0..p_resp_depth):
  - +1 on request fire, -1 on response fire; unchanged when both fire in the same cycle.
  - reqstream_rdy = (reset==1) && (cnt < p_resp_depth).
  - reqstream_rdy has no combinational dependence on respstream_rdy or reqstream_val.
- Latency:
  - A request firing at edge t produces respstream_val=1 in the cycle after edge t+p_latency-1, i.e. p_latency cycles later, when nothing is queued ahead of it.
  - With backpressure, responses wait in the output buffer. The buffer never overflows because of the credit counter, and the latency pipeline never stalls.
  - Responses leave in strict request order.
- Addressing:
  - Word index = addr[2 +: log2(p_mem_nwords)]. Upper address bits are ignored, so addresses wrap modulo 4*p_mem_nwords.
  - Byte offset = addr[1:0].
  - Number of bytes nb = (len==0) ? 4 : len.
  - A request is misaligned when offset+nb > 4.
- Ordering:
  - Storage is read and written at request-fire time.
  - A write followed by a read of the same word on the next accepted request returns the new data.
- READ (type_ 0):
  - Response data = storage word >> (8*offset), masked to nb bytes and zero-extended.
- WRITE (type_ 1) and INIT (type_ 2):
  - Only bytes offset..offset+nb-1 of the word are updated, taking request data bytes 0..nb-1.
  - Response data = 0.
- Response fields: type_, opaque and len are echoed from the request. test = 2'b00.
- Misaligned requests and unknown type_ (3..7):
  - No storage update.
  - A response is still returned, with data=0 and test=2'b01. type_, opaque and len are echoed.
- Simultaneous events:
  - Request fire and response fire in the same cycle are both honoured.
  - A request fire in the same cycle that cnt reaches p_resp_depth is impossible, since rdy is computed from registered cnt.

Test Plan:
- Write/read back:
  - WRITE addr 0x0000_0010 data 0xDEADBEEF len 0 opaque 0x05 -> resp type 1, opaque 0x05, data 0, test 0.
  - Then READ 0x10 -> data 0xDEADBEEF.
- Sub-word:
  - Word 0x10 = 0xDEADBEEF. WRITE addr 0x12 len 1 data 0x000000AA -> READ 0x10 len 0 returns 0xDEAABEEF.
  - READ 0x11 len 2 -> 0x0000AABE.
- Latency: p_latency=3, respstream_rdy held 1, READ fires at edge 10 -> respstream_val first high after edge 12; opaque and order preserved across 4 back-to-back reads.
- Backpressure: p_resp_depth=2, respstream_rdy=0 -> exactly 2 requests accepted, reqstream_rdy=0 thereafter. Raise respstream_rdy -> 2 responses drain in order, then rdy returns to 1.
- Misaligned and wrap:
  - WRITE addr 0x03 len 2 -> test 2'b01, storage unchanged.
  - With p_mem_nwords=256, WRITE 0x400 then READ 0x000 -> same data.
- Reset mid-operation: 2 responses in flight, drive reset=0 asynchronously between edges -> respstream_val drops before the next edge. Release reset -> reqstream_rdy=1 and no stale response ever appears.
